// File: rtl/lfsr_crypt_pkg.sv
// ---------------------------------------------------------------------------
// lfsr_crypt_pkg
// Shared definitions for the LFSR stream-cipher engine.
//   state_t : control FSM states
//   SPACE   : pad character written around the message in a frame
//   tap_of  : tap pattern lookup, index 0..8, unknown index returns no taps
//   par7    : parity over the 7 data bits of a cipher byte
// ---------------------------------------------------------------------------
package lfsr_crypt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [7:0] SPACE = 8'h20;

    function automatic logic [6:0] tap_of(input logic [3:0] idx);
        logic [6:0] t;
        case (idx)
            4'd0:    t = 7'h60;
            4'd1:    t = 7'h48;
            4'd2:    t = 7'h78;
            4'd3:    t = 7'h72;
            4'd4:    t = 7'h6A;
            4'd5:    t = 7'h69;
            4'd6:    t = 7'h5C;
            4'd7:    t = 7'h7E;
            4'd8:    t = 7'h7B;
            default: t = 7'h00;
        endcase
        return t;
    endfunction

    function automatic logic par7(input logic [6:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/lfsr_crypt_engine_if.sv
// ---------------------------------------------------------------------------
// lfsr_crypt_engine_if
// Byte streams of the engine: source (in_*) and result (out_*), both
// valid/ready handshakes.
//   master : the environment (drives source, accepts results)
//   slave  : the engine
// ---------------------------------------------------------------------------
interface lfsr_crypt_engine_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/lfsr_gen.sv
// ---------------------------------------------------------------------------
// lfsr_gen
// Keystream LFSR register: s_next = {s[W-2:0], ^(s & taps)}.
//   clk, init_n : clock, synchronous active-low reset (state -> 0)
//   i_load      : load i_seed (wins over i_adv)
//   i_seed      : seed value
//   i_adv       : step the register once
//   i_sel       : tap-pattern index
//   o_state     : current state
//   o_next      : state after one step (lets the caller look ahead)
// ---------------------------------------------------------------------------
module lfsr_gen
    import lfsr_crypt_pkg::*;
#(
    parameter int LFSR_W = 7
) (
    input  logic              clk,
    input  logic              init_n,
    input  logic              i_load,
    input  logic [LFSR_W-1:0] i_seed,
    input  logic              i_adv,
    input  logic [3:0]        i_sel,
    output logic [LFSR_W-1:0] o_state,
    output logic [LFSR_W-1:0] o_next
);
    logic [LFSR_W-1:0] r_lfsr;
    logic [6:0]        w_tap7;
    logic [LFSR_W-1:0] w_taps;

    assign w_tap7  = tap_of(i_sel);
    assign w_taps  = LFSR_W'(w_tap7);
    assign o_next  = {r_lfsr[LFSR_W-2:0], ^(r_lfsr & w_taps)};
    assign o_state = r_lfsr;

    // LFSR state register: reset, load or step
    always_ff @(posedge clk) begin
        if (!init_n) begin
            r_lfsr <= '0;
        end else if (i_load) begin
            r_lfsr <= i_seed;
        end else if (i_adv) begin
            r_lfsr <= o_next;
        end else begin
            r_lfsr <= r_lfsr;
        end
    end
endmodule

// File: rtl/lfsr_crypt_engine.sv
// ---------------------------------------------------------------------------
// lfsr_crypt_engine
// Frames and encrypts a message with an LFSR keystream, or decrypts a frame.
//   clk, init_n : clock, synchronous active-low reset
//   bgn         : start request (IDLE / DONE)
//   mode        : 0 encrypt, 1 decrypt
//   pt_no       : tap-pattern index
//   lfsr_init   : seed (0 is replaced by 1)
//   pre_length  : leading pad bytes
//   msg_len     : message characters (encrypt)
//   s_if        : source / result byte streams
//   ack         : run complete (DONE)
//   cfg_err     : illegal pt_no at start
//   par_err     : sticky decrypt parity failure
//   err_cnt     : decrypt parity failures, saturating
// ---------------------------------------------------------------------------
module lfsr_crypt_engine
    import lfsr_crypt_pkg::*;
#(
    parameter int LFSR_W    = 7,
    parameter int FRAME_LEN = 64,
    parameter int MAX_MSG   = 49,
    parameter int NUM_PTRN  = 9
) (
    input  logic               clk,
    input  logic               init_n,
    input  logic               bgn,
    input  logic               mode,
    input  logic [3:0]         pt_no,
    input  logic [LFSR_W-1:0]  lfsr_init,
    input  logic [7:0]         pre_length,
    input  logic [5:0]         msg_len,
    lfsr_crypt_engine_if.slave s_if,
    output logic               ack,
    output logic               cfg_err,
    output logic               par_err,
    output logic [6:0]         err_cnt
);
    localparam logic [7:0] FRAME_B = 8'(FRAME_LEN);
    localparam logic [7:0] MAX_B   = 8'(MAX_MSG);
    localparam logic [3:0] NPTRN_B = 4'(NUM_PTRN);

    state_t            r_state, w_state_nxt;
    logic              r_mode;
    logic [3:0]        r_pt;
    logic [7:0]        r_pre, r_msg_end, r_idx;
    logic              r_out_valid;
    logic [7:0]        r_out_data;
    logic              r_cfg_err, r_par_err;
    logic [6:0]        r_err_cnt;

    logic [7:0]        w_msg_clip, w_msg_eff;
    logic [8:0]        w_sum;
    logic [LFSR_W-1:0] w_seed, w_lfsr, w_lfsr_nxt, w_ks;
    logic [6:0]        w_ks7, w_p7, w_c7;
    logic [7:0]        w_byte;
    logic              w_run, w_in_msg, w_space, w_in_rdy, w_in_hs, w_out_hs;
    logic              w_gen, w_emit, w_adv, w_last, w_bad, w_load;

    assign w_seed = (lfsr_init == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : lfsr_init;
    assign w_load = (r_state == LOAD);

    lfsr_gen #(.LFSR_W(LFSR_W)) u_gen (
        .clk     (clk),
        .init_n  (init_n),
        .i_load  (w_load),
        .i_seed  (w_seed),
        .i_adv   (w_adv),
        .i_sel   (r_pt),
        .o_state (w_lfsr),
        .o_next  (w_lfsr_nxt)
    );

    // Clip the requested message length so message plus pad fits the frame
    always_comb begin
        w_msg_clip = {2'b00, msg_len};
        w_msg_eff  = 8'd0;
        w_sum      = 9'd0;
        if ({2'b00, msg_len} > MAX_B) begin
            w_msg_clip = MAX_B;
        end else begin
            w_msg_clip = {2'b00, msg_len};
        end
        w_sum = {1'b0, pre_length} + {1'b0, w_msg_clip};
        if (pre_length >= FRAME_B) begin
            w_msg_eff = 8'd0;
        end else if (w_sum > {1'b0, FRAME_B}) begin
            w_msg_eff = FRAME_B - pre_length;
        end else begin
            w_msg_eff = w_msg_clip;
        end
    end

    // Byte-slot datapath: when a byte is produced, which key, what value
    always_comb begin
        w_run    = (r_state == RUN);
        w_in_msg = (r_idx >= r_pre) && (r_idx < r_msg_end);
        // result register free now, or emptied by this cycle's handshake
        w_space  = (r_idx < FRAME_B) && (!r_out_valid || s_if.out_ready);
        w_out_hs = init_n && r_out_valid && s_if.out_ready;
        w_in_rdy = 1'b0;
        w_gen    = 1'b0;
        w_emit   = 1'b0;
        w_ks     = w_lfsr;
        if (r_mode) begin
            w_in_rdy = init_n && w_run && w_space;
            w_gen    = w_run && w_space && s_if.in_valid;
            w_emit   = w_gen && (r_idx >= r_pre);
            w_ks     = w_lfsr;
        end else begin
            w_in_rdy = init_n && w_run && w_space && w_in_msg;
            w_gen    = w_run && w_space && (!w_in_msg || s_if.in_valid);
            w_emit   = w_gen;
            // the key steps on the result handshake; a byte built in that
            // same cycle must already use the stepped key
            w_ks     = w_out_hs ? w_lfsr_nxt : w_lfsr;
        end
        w_in_hs = w_in_rdy && s_if.in_valid;
        w_adv   = w_run && (r_mode ? w_in_hs : w_out_hs);
        w_ks7   = 7'(w_ks);
        w_p7    = (!r_mode && !w_in_msg) ? SPACE[6:0] : s_if.in_data[6:0];
        w_c7    = w_p7 ^ w_ks7;
        w_byte  = r_mode ? {1'b0, w_c7} : {par7(w_c7), w_c7};
        w_last  = w_run && (r_idx >= FRAME_B) && (!r_out_valid || s_if.out_ready);
        w_bad   = r_mode && w_in_hs && (s_if.in_data[7] != par7(s_if.in_data[6:0]));
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = bgn ? LOAD : IDLE;
            LOAD:    w_state_nxt = (pt_no >= NPTRN_B) ? DONE : RUN;
            RUN:     w_state_nxt = w_last ? DONE : RUN;
            DONE:    w_state_nxt = bgn ? LOAD : DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!init_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Configuration latch, frame index, result register and error status
    always_ff @(posedge clk) begin
        if (!init_n) begin
            r_mode      <= 1'b0;
            r_pt        <= 4'd0;
            r_pre       <= 8'd0;
            r_msg_end   <= 8'd0;
            r_idx       <= 8'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
            r_cfg_err   <= 1'b0;
            r_par_err   <= 1'b0;
            r_err_cnt   <= 7'd0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bgn) begin
                        r_cfg_err <= 1'b0;
                        r_par_err <= 1'b0;
                        r_err_cnt <= 7'd0;
                    end
                end
                LOAD: begin
                    r_mode      <= mode;
                    r_pt        <= pt_no;
                    r_pre       <= pre_length;
                    r_msg_end   <= pre_length + w_msg_eff;
                    r_idx       <= 8'd0;
                    r_out_valid <= 1'b0;
                    r_cfg_err   <= (pt_no >= NPTRN_B);
                end
                RUN: begin
                    if (w_gen) begin
                        r_idx <= r_idx + 8'd1;
                    end
                    if (w_emit) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_byte;
                    end else if (w_out_hs) begin
                        r_out_valid <= 1'b0;
                    end
                    if (w_bad) begin
                        r_par_err <= 1'b1;
                        if (r_err_cnt != 7'h7F) begin
                            r_err_cnt <= r_err_cnt + 7'd1;
                        end
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // valid/ready are masked while init_n is low so no transfer completes
    assign s_if.in_ready  = w_in_rdy;
    assign s_if.out_valid = r_out_valid && init_n;
    assign s_if.out_data  = r_out_data;
    assign ack            = (r_state == DONE);
    assign cfg_err        = r_cfg_err;
    assign par_err        = r_par_err;
    assign err_cnt        = r_err_cnt;
endmodule

// File: tb/tb_lfsr_crypt_engine.sv
module tb_lfsr_crypt_engine;
    logic       clk = 1'b0;
    logic       init_n, bgn, mode;
    logic [3:0] pt_no;
    logic [6:0] lfsr_init;
    logic [7:0] pre_length;
    logic [5:0] msg_len;
    logic       ack, cfg_err, par_err;
    logic [6:0] err_cnt;

    lfsr_crypt_engine_if bus ();

    lfsr_crypt_engine dut (
        .clk        (clk),
        .init_n     (init_n),
        .bgn        (bgn),
        .mode       (mode),
        .pt_no      (pt_no),
        .lfsr_init  (lfsr_init),
        .pre_length (pre_length),
        .msg_len    (msg_len),
        .s_if       (bus),
        .ack        (ack),
        .cfg_err    (cfg_err),
        .par_err    (par_err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    logic [7:0] src[$];
    logic [7:0] msg_bytes [64];
    logic [6:0] tb_taps [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};
    int         first_v;
    int         consumed;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s observed 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference frame: for encrypt exp_q gets cipher bytes; for decrypt the
    // cipher goes to src and exp_q gets the plaintext from pre onward.
    task automatic build_ref(input int pt, input logic [6:0] seed, input int pre,
                             input int len, input bit dec);
        logic [6:0] s, c;
        logic [7:0] p;
        exp_q.delete();
        s = (seed == 7'd0) ? 7'd1 : seed;
        for (int i = 0; i < 64; i++) begin
            if (i >= pre && i < pre + len) p = msg_bytes[i - pre];
            else                           p = 8'h20;
            c = p[6:0] ^ s;
            if (dec) begin
                src.push_back({^c, c});
                if (i >= pre) exp_q.push_back({1'b0, p[6:0]});
            end else begin
                exp_q.push_back({^c, c});
            end
            s = {s[5:0], ^(s & tb_taps[pt])};
        end
    endtask

    function automatic int frame_miss();
        int n = 0;
        if (got.size() != exp_q.size()) n++;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (got[i] !== exp_q[i]) n++;
        return n;
    endfunction

    task automatic run_frame(input logic m, input logic [3:0] pt, input logic [6:0] seed,
                             input logic [7:0] pre, input logic [5:0] len,
                             input int stall_at, input int rst_at);
        int         cyc, hs, stall_n, src0;
        logic [7:0] held;
        bit         fin;
        got.delete();
        first_v = -1; cyc = 0; hs = 0; stall_n = 0; fin = 0; held = 8'h00;
        src0 = src.size();
        mode = m; pt_no = pt; lfsr_init = seed; pre_length = pre; msg_len = len;
        bgn = 1'b1;
        @(negedge clk);
        bgn = 1'b0;
        while (!fin && cyc < 2000) begin
            bus.out_ready = 1'b1;
            if (stall_at >= 0 && hs == stall_at && stall_n < 3) begin
                bus.out_ready = 1'b0;
                stall_n++;
            end
            bus.in_valid = (src.size() > 0);
            bus.in_data  = (src.size() > 0) ? src[0] : 8'h00;
            if (rst_at >= 0 && hs == rst_at) begin
                init_n = 1'b0;
                fin    = 1'b1;
            end
            #1;
            if (bus.out_valid && first_v < 0) first_v = cyc;
            if (!bus.out_ready) begin
                if (stall_n == 1) held = bus.out_data;
                else check_eq("stall_hold", bus.out_data, held);
                check_eq("stall_valid", bus.out_valid, 1);
            end
            if (bus.out_valid && bus.out_ready) begin
                got.push_back(bus.out_data);
                hs++;
            end
            if (bus.in_valid && bus.in_ready) void'(src.pop_front());
            if (ack) fin = 1'b1;
            cyc++;
            @(negedge clk);
        end
        check_eq("run_terminates", fin, 1);
        consumed = src0 - src.size();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        init_n = 1'b0; bgn = 1'b0; mode = 1'b0; pt_no = 4'd0; lfsr_init = 7'd0;
        pre_length = 8'd0; msg_len = 6'd0;
        bus.in_valid = 1'b0; bus.in_data = 8'h00; bus.out_ready = 1'b1;
        for (int i = 0; i < 64; i++) msg_bytes[i] = 8'h41 + 8'(i);
        msg_bytes[3] = 8'hC4;   // bit 7 set: must not reach the cipher
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_in_ready", bus.in_ready, 0);
        check_eq("rst_out_data", bus.out_data, 8'h00);
        check_eq("rst_ack", ack, 0);
        check_eq("rst_errs", {cfg_err, par_err, err_cnt}, 0);
        @(negedge clk);
        init_n = 1'b1;

        // pure pad frame, seed 1, taps 0x60
        src.delete();
        build_ref(0, 7'h01, 10, 0, 0);
        run_frame(1'b0, 4'd0, 7'h01, 8'd10, 6'd0, -1, -1);
        check_eq("pad_count", got.size(), 64);
        check_eq("pad_byte0", got[0], 8'h21);
        check_eq("pad_byte1", got[1], 8'h22);
        check_eq("pad_byte5", got[5], 8'h00);
        check_eq("pad_byte6", got[6], 8'hE1);
        check_eq("pad_frame", frame_miss(), 0);
        check_eq("pad_latency_ok", (first_v >= 2), 1);
        check_eq("pad_ack", ack, 1);

        // zero seed behaves as seed 1
        run_frame(1'b0, 4'd0, 7'h00, 8'd10, 6'd0, -1, -1);
        check_eq("seed0_frame", frame_miss(), 0);

        // illegal tap pattern
        run_frame(1'b0, 4'd9, 7'h01, 8'd10, 6'd0, -1, -1);
        check_eq("cfg_err", cfg_err, 1);
        check_eq("cfg_ack", ack, 1);
        check_eq("cfg_no_out", got.size(), 0);

        // decrypt with corrupted parity on byte 20
        src.delete();
        build_ref(3, 7'h55, 10, 12, 1);
        src[20] = src[20] ^ 8'h80;
        run_frame(1'b1, 4'd3, 7'h55, 8'd10, 6'd0, -1, -1);
        check_eq("dec_par_err", par_err, 1);
        check_eq("dec_err_cnt", err_cnt, 1);
        check_eq("dec_count", got.size(), 54);
        check_eq("dec_frame", frame_miss(), 0);
        check_eq("dec_consumed", consumed, 64);
        check_eq("dec_cfg_clear", cfg_err, 0);

        // encrypt message with a 3-cycle stall mid-frame
        src.delete();
        for (int i = 0; i < 12; i++) src.push_back(msg_bytes[i]);
        build_ref(3, 7'h55, 5, 12, 0);
        run_frame(1'b0, 4'd3, 7'h55, 8'd5, 6'd12, 20, -1);
        check_eq("stall_frame", frame_miss(), 0);
        check_eq("msg_consumed", consumed, 12);
        check_eq("par_clear", {par_err, err_cnt}, 0);

        // pre + msg overflow: 60 -> 49 -> 44
        src.delete();
        for (int i = 0; i < 60; i++) src.push_back(msg_bytes[i]);
        build_ref(8, 7'h7F, 20, 44, 0);
        run_frame(1'b0, 4'd8, 7'h7F, 8'd20, 6'd60, -1, -1);
        check_eq("clip_frame", frame_miss(), 0);
        check_eq("clip_consumed", consumed, 44);

        // msg_len above MAX_MSG only
        src.delete();
        for (int i = 0; i < 55; i++) src.push_back(msg_bytes[i]);
        build_ref(5, 7'h33, 0, 49, 0);
        run_frame(1'b0, 4'd5, 7'h33, 8'd0, 6'd55, -1, -1);
        check_eq("max_frame", frame_miss(), 0);
        check_eq("max_consumed", consumed, 49);

        // reset at byte 30 of a run
        src.delete();
        run_frame(1'b0, 4'd0, 7'h01, 8'd10, 6'd0, -1, 30);
        init_n = 1'b1;
        #1;
        check_eq("mid_rst_bytes", got.size(), 30);
        check_eq("mid_rst_out_valid", bus.out_valid, 0);
        check_eq("mid_rst_in_ready", bus.in_ready, 0);
        check_eq("mid_rst_out_data", bus.out_data, 8'h00);
        check_eq("mid_rst_ack", ack, 0);
        check_eq("mid_rst_lfsr", dut.u_gen.r_lfsr, 0);

        // fresh run after reset
        build_ref(0, 7'h01, 10, 0, 0);
        run_frame(1'b0, 4'd0, 7'h01, 8'd10, 6'd0, -1, -1);
        check_eq("post_rst_frame", frame_miss(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
